// File: rtl/debayer_pkg.sv
// Shared types for the Bayer quad assembler and the downstream debayer stage.
package debayer_pkg;

   typedef logic [7:0] pixel_t;

   typedef struct packed {
      pixel_t r;
      pixel_t g1;
      pixel_t g2;
      pixel_t b;
   } quad_t;

   typedef enum logic {
      ROW_EVEN = 1'b0,
      ROW_ODD  = 1'b1
   } row_state_e;

endpackage

// File: rtl/bayer_line_buf.sv
// Even-row line buffer: one {R,G1} pair per 2x2 tile. It has a synchronous write port and an asynchronous read port.
module bayer_line_buf #(
   parameter int unsigned DEPTH = 320,
   parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [15:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [15:0]   rdata_o
);

   logic [15:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bayer_quad_assembler.sv
// Pairs each buffered even RGGB row with the following odd row and emits one {R,G1,G2,B} quad per tile.
// Optional BAYER_SOF_SYNC_EN adds an sof input that resyncs the position to row 0, col 0.
module bayer_quad_assembler
   import debayer_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  pixel_in,
   input  logic        pixel_valid,
   output logic        pixel_ready,
`ifdef BAYER_SOF_SYNC_EN
   input  logic        sof,
`endif
   output logic [31:0] quad_out,
   output logic        quad_valid,
   input  logic        quad_ready,
   output logic        frame_done
);

   localparam int unsigned CW    = $clog2(IMG_WIDTH);
   localparam int unsigned RW    = $clog2(IMG_HEIGHT);
   localparam int unsigned DEPTH = IMG_WIDTH / 2;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   row_state_e    state_q, state_d, eff_state;
   logic [CW-1:0] col_q, col_d, eff_col;
   logic [RW-1:0] row_q, row_d, eff_row;
   pixel_t        r_hold_q, r_hold_d, g2_hold_q, g2_hold_d;
   quad_t         quad_q, quad_d;
   logic          quad_valid_q, quad_valid_d;
   logic          frame_done_q, frame_done_d;

   logic          accept, resync, odd_col, col_last, row_last, quad_load;
   logic          lb_we;
   logic [AW-1:0] lb_addr;
   logic [15:0]   lb_rdata;

   assign pixel_ready = !(quad_valid_q && !quad_ready);
   assign accept      = pixel_valid && pixel_ready;

`ifdef BAYER_SOF_SYNC_EN
   assign resync = accept && sof;
`else
   assign resync = 1'b0;
`endif

   // An sof pixel is decoded as if the counters already sat at row 0 col 0,
   // so resync and normal counting share one datapath.
   assign eff_state = resync ? ROW_EVEN : state_q;
   assign eff_col   = resync ? '0 : col_q;
   assign eff_row   = resync ? '0 : row_q;

   assign odd_col  = eff_col[0];
   assign col_last = (eff_col == CW'(IMG_WIDTH - 1));
   assign row_last = (eff_row == RW'(IMG_HEIGHT - 2));
   assign lb_addr  = AW'(eff_col >> 1);
   assign lb_we    = accept && (eff_state == ROW_EVEN) && odd_col;

   bayer_line_buf #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_line_buf (
      .clk_i   (clk),
      .we_i    (lb_we),
      .waddr_i (lb_addr),
      .wdata_i ({r_hold_q, pixel_in}),
      .raddr_i (lb_addr),
      .rdata_o (lb_rdata)
   );

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      r_hold_d     = r_hold_q;
      g2_hold_d    = g2_hold_q;
      quad_d       = quad_q;
      quad_load    = 1'b0;
      frame_done_d = 1'b0;
      if (accept) begin
         state_d = eff_state;
         row_d   = eff_row;
         if (!odd_col) begin
            if (eff_state == ROW_EVEN) r_hold_d  = pixel_in;
            else                       g2_hold_d = pixel_in;
         end else if (eff_state == ROW_ODD) begin
            quad_load    = 1'b1;
            quad_d       = '{r: lb_rdata[15:8], g1: lb_rdata[7:0], g2: g2_hold_q, b: pixel_in};
            frame_done_d = col_last && row_last;
         end
         if (col_last) begin
            col_d = '0;
            if (eff_state == ROW_EVEN) begin
               state_d = ROW_ODD;
            end else begin
               state_d = ROW_EVEN;
               row_d   = row_last ? '0 : eff_row + RW'(2);
            end
         end else begin
            col_d = eff_col + CW'(1);
         end
      end
      if (quad_load)       quad_valid_d = 1'b1;
      else if (quad_ready) quad_valid_d = 1'b0;
      else                 quad_valid_d = quad_valid_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ROW_EVEN;
         col_q        <= '0;
         row_q        <= '0;
         r_hold_q     <= '0;
         g2_hold_q    <= '0;
         quad_q       <= '0;
         quad_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         r_hold_q     <= r_hold_d;
         g2_hold_q    <= g2_hold_d;
         quad_q       <= quad_d;
         quad_valid_q <= quad_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign quad_out   = quad_q;
   assign quad_valid = quad_valid_q;
   assign frame_done = frame_done_q;

endmodule
